// File: rtl/pio_edge_in_pkg.sv
// pio_edge_in_pkg: register addresses, edge-mode encoding and edge selection shared by pio_edge_in
package pio_edge_in_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;
  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF} edge_mode_t;
  function automatic logic [31:0] edge_select(edge_mode_t m, logic [31:0] rise, logic [31:0] fall);
    return m == EDGE_RISE ? rise : m == EDGE_FALL ? fall : m == EDGE_BOTH ? (rise | fall) : 32'd0;
  endfunction
endpackage

// File: rtl/pio_edge_in_debounce.sv
// pio_edge_in_debounce: one channel; clean follows sync_in only after DEBOUNCE_CYCLES stable samples
module pio_edge_in_debounce
  import pio_edge_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic clean
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (sync_in == clean) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      clean <= sync_in;
      cnt   <= '0;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/pio_edge_in.sv
// pio_edge_in: Avalon-MM input PIO with sync, per-channel edge capture (W1C) and masked irq
// Optional per-channel debounce enabled by defining PIO_EDGE_IN_DEBOUNCE_EN.
module pio_edge_in
  import pio_edge_in_pkg::*;
#(
  parameter int         WIDTH           = 4,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [1:0] RESET_MODE      = 2'b01
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] s1, s2, clean, clean_q, capture, mask, rise, fall, edges, w1c;
  edge_mode_t mode;
  logic wr;
  logic [31:0] rd_next;
  logic unused_ok;
  assign wr = chipselect & ~write_n;
  assign unused_ok = ^{writedata, 32'(DEBOUNCE_CYCLES)};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
`ifdef PIO_EDGE_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_edge_in_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .sync_in(s2[i]),
      .clean  (clean[i])
    );
  end
`else
  assign clean = s2;
`endif
  assign rise  = clean & ~clean_q;
  assign fall  = ~clean & clean_q;
  assign edges = WIDTH'(edge_select(mode, 32'(rise), 32'(fall)));
  assign w1c   = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;
  assign rd_next = address == ADDR_DATA ? 32'(clean) :
                   address == ADDR_MODE ? {30'd0, mode} :
                   address == ADDR_MASK ? 32'(mask) : 32'(capture);
  assign irq = |(capture & mask);
  // a new edge overrides a same-cycle W1C so no event is lost
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      clean_q  <= '0;
      capture  <= '0;
      mask     <= '0;
      mode     <= edge_mode_t'(RESET_MODE);
      readdata <= '0;
    end else begin
      clean_q  <= clean;
      capture  <= (capture & ~w1c) | edges;
      readdata <= rd_next;
      if (wr && address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_MODE) mode <= edge_mode_t'(writedata[1:0]);
    end
endmodule

// File: doc/pio_edge_in.md
# pio_edge_in

Parametrised Avalon-MM input PIO for the Tetris button/switch inputs, superseding the single-bit edge-capture PIO blocks. It synchronises a WIDTH-bit input bus, optionally debounces each channel, and detects edges per channel with a software-selected edge mode. It also keeps per-bit edge-capture flags with write-1-to-clear, and raises a masked level interrupt to the Nios II. It sits between board pins (KEY/SW) and the system interconnect.

## Interface
- WIDTH, 4: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a channel changes; ≥1; used only with PIO_EDGE_IN_DEBOUNCE_EN.
- RESET_MODE, 2'b01: edge-mode register reset value.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous input pins
- readdata  out  32  registered read data; reset 0
- irq  out  1  level interrupt; reset 0

## Operation
- Register map, all reads zero-extended:
  - 0 DATA: RO, the conditioned input value `clean`. Writes are ignored.
  - 1 MODE: RW, bits [1:0]. 0 = rising, 1 = falling, 2 = both edges, 3 = detection off.
  - 2 MASK: RW, bits [WIDTH-1:0].
  - 3 CAPTURE: R/W1C. For each bit i with writedata[i]=1, capture[i] is cleared.
- Input path per channel:
  - in_port feeds a 2-flop synchroniser, s1 then s2.
  - Without debounce, clean = s2.
  - clean_q is clean delayed by 1 cycle.
- Edge detect per channel:
  - rise = clean & ~clean_q
  - fall = ~clean & clean_q
  - edge = selected by MODE (rise, fall, rise|fall, or 0).
- Capture per bit:
  - edge sets capture[i] to 1; the bit is sticky.
  - A W1C write of the same bit in the same cycle as an edge leaves the bit set. The edge wins.
- irq = |(capture & mask). It is combinational from registers and needs no chipselect.
- Writes to MASK or MODE take effect the next cycle. Existing capture bits are unaffected.
- Reset values are 0 everywhere except MODE = RESET_MODE. This covers s1, s2, clean, clean_q, capture, mask, counters and readdata.
- Reset is asynchronous at any point, including mid-debounce. All counters clear.
- A channel held high through reset produces a rise, and is captured if MODE is 0 or 2.

## Timing
- readdata:
  - Registered on every clk, whatever chipselect is, from the address presented that cycle.
  - Read latency is 1.
- Without debounce:
  - in_port is sampled at edge 1 and s2 updates at edge 2.
  - capture and irq update at edge 3.
  - DATA reflects the change in a read issued after edge 2.
- With debounce:
  - clean toggles at edge 2+DEBOUNCE_CYCLES.
  - capture updates at edge 3+DEBOUNCE_CYCLES.
- Minimum detectable pulse:
  - Without debounce: 1 clk, if the pulse is sampled.
  - With debounce: DEBOUNCE_CYCLES consecutive samples.

## Configuration
- PIO_EDGE_IN_DEBOUNCE_EN defined:
  - Each channel has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When s2 == clean, the counter is cleared to 0.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while s2 still differs, clean <= s2 and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is ignored.
- PIO_EDGE_IN_DEBOUNCE_EN undefined:
  - No counters; clean = s2.
  - DEBOUNCE_CYCLES is ignored.

## Structure
- Package pio_edge_in_pkg:
  - Address constants ADDR_DATA, ADDR_MODE, ADDR_MASK, ADDR_CAPTURE.
  - Edge-mode enum edge_mode_t: EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF.
- Sub-module pio_edge_in_debounce:
  - One channel with counter and clean register.
  - Generated WIDTH times, only under PIO_EDGE_IN_DEBOUNCE_EN.

## Test plan
- Falling edge, WIDTH=4, no debounce, mode 1:
  - Stimulus: reset, in_port=4'hF; write MASK=4'h2; drop in_port[1] at edge 0.
  - Response: capture=4'h2 and irq=1 at edge 3; read CAPTURE returns 32'h2.
- W1C priority, bits 1 and 0 set:
  - Stimulus: write CAPTURE=4'h1.
  - Response: capture=4'h2. Then write 4'h2 in the same cycle as a new edge on bit 1; capture[1] stays 1.
- Modes on bit 0:
  - Stimulus: pulse bit 0 high for 5 cycles under each mode.
  - Response: mode 0 captures at the rise only; mode 2 captures at either edge (clear between); mode 3 never captures.
- Debounce, macro defined, DEBOUNCE_CYCLES=4:
  - Stimulus: 3-cycle glitch.
  - Response: no DATA change and no capture.
  - Stimulus: 6-cycle level.
  - Response: capture at edge 7 after the sample edge.
- Reset mid-debounce:
  - Stimulus: assert reset_n=0 while a counter is at 2.
  - Response: readdata, irq, capture, mask = 0; MODE = RESET_MODE; no spurious capture after release with in_port=0.
- Read path:
  - Stimulus: read each address.
  - Response: 1-cycle latency. DATA=zero-extended clean; MODE returns 32'h1 after reset.
